// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and frame-format constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_STOP_BITS  = 1;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous circular-buffer FIFO. Pointers carry one extra wrap bit, so
// full/empty come from pointer comparison alone, with no occupancy counter.
// full and empty are registered, computed from the next-state pointers.
// rd_data shows the head entry combinationally.
//
// Ports:
//   clk_sys  : clock, rising edge
//   rst_b    : asynchronous active-low reset
//   wr_en    : write strobe (ignored while full)
//   wr_data  : data to enqueue
//   rd_en    : read/pop strobe (ignored while empty)
//   rd_data  : head entry
//   full     : FIFO holds DEPTH entries
//   empty    : FIFO holds no entries
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_sys,
    input  logic             rst_b,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic [AW:0]      rd_ptr_nxt;
    logic             wr_ok;
    logic             rd_ok;

    // Full is judged on the current flags, so a write while full is dropped
    // even when a pop happens in the same cycle.
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    assign wr_ptr_nxt = wr_ptr + (AW+1)'(wr_ok);
    assign rd_ptr_nxt = rd_ptr + (AW+1)'(rd_ok);

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter. Host bytes are queued in a FIFO and shifted
// out LSB first on UART_TX_O, one bit per C_OVERSAMPLE baud_tick pulses.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line high; pops the head byte when Enable=1 and FIFO not empty
// START | start bit (line low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (line high); may pop the next byte for a back-to-back frame
//
// Ports:
//   Clk        : clock, rising edge
//   Resetn     : asynchronous active-low reset
//   baud_tick  : one-cycle pulse at C_OVERSAMPLE x baud rate
//   Enable     : allows new frames to start; never aborts a running frame
//   TX_data    : byte to enqueue
//   wr_uart_en : write strobe, accepted when Full=0
//   Full       : FIFO holds DATA_DEPTH bytes
//   Empty      : FIFO holds no bytes
//   Busy       : a frame is being shifted
//   Write_drop : one-cycle pulse after a write that arrived while Full=1
//   UART_TX_O  : serial output, idles high
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_DEPTH   = 16,
    parameter int C_OVERSAMPLE = 16
) (
    input  logic       Clk,
    input  logic       Resetn,
    input  logic       baud_tick,
    input  logic       Enable,
    input  logic [7:0] TX_data,
    input  logic       wr_uart_en,
    output logic       Full,
    output logic       Empty,
    output logic       Busy,
    output logic       Write_drop,
    output logic       UART_TX_O
);

    localparam int TW = $clog2(C_OVERSAMPLE);

    uart_tx_state_e state;
    logic [TW-1:0]  tick_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_reg;
    logic [7:0]     fifo_head;
    logic           bit_end;
    logic           can_start;
    logic           pop;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DATA_DEPTH)
    ) u_fifo (
        .clk_sys (Clk),
        .rst_b   (Resetn),
        .wr_en   (wr_uart_en),
        .wr_data (TX_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (Full),
        .empty   (Empty)
    );

    // The terminal tick of a bit period is the one that wraps the counter.
    assign bit_end   = baud_tick && (tick_cnt == TW'(C_OVERSAMPLE - 1));
    assign can_start = Enable && !Empty;

    // Pop happens in the same cycle the head byte is captured into shift_reg.
    assign pop = ((state == IDLE) && can_start) ||
                 ((state == STOP) && bit_end && can_start);

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            UART_TX_O  <= UART_IDLE_LEVEL;
            Busy       <= 1'b0;
            Write_drop <= 1'b0;
        end else begin
            Write_drop <= wr_uart_en & Full;

            if (baud_tick && (state != IDLE)) begin
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        shift_reg <= fifo_head;
                        tick_cnt  <= '0;
                        bit_cnt   <= '0;
                        UART_TX_O <= 1'b0;
                        Busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        UART_TX_O <= shift_reg[0];
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
                            UART_TX_O <= UART_IDLE_LEVEL;
                            state     <= STOP;
                        end else begin
                            // Drive the next bit directly from the unshifted value.
                            shift_reg <= shift_reg >> 1;
                            UART_TX_O <= shift_reg[1];
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift_reg <= fifo_head;
                            tick_cnt  <= '0;
                            bit_cnt   <= '0;
                            UART_TX_O <= 1'b0;
                            state     <= START;
                        end else begin
                            Busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    UART_TX_O <= UART_IDLE_LEVEL;
                    Busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: C_OVERSAMPLE=16, baud_tick every 4th
// cycle (64 cycles per bit). Outputs are sampled on the falling clock edge.
module tb_uart_tx_buffered;

    logic       Clk;
    logic       Resetn;
    logic       baud_tick;
    logic       Enable;
    logic [7:0] TX_data;
    logic       wr_uart_en;
    logic       Full;
    logic       Empty;
    logic       Busy;
    logic       Write_drop;
    logic       UART_TX_O;

    int checks = 0;
    int errors = 0;

    uart_tx_buffered #(
        .DATA_DEPTH   (16),
        .C_OVERSAMPLE (16)
    ) dut (
        .Clk        (Clk),
        .Resetn     (Resetn),
        .baud_tick  (baud_tick),
        .Enable     (Enable),
        .TX_data    (TX_data),
        .wr_uart_en (wr_uart_en),
        .Full       (Full),
        .Empty      (Empty),
        .Busy       (Busy),
        .Write_drop (Write_drop),
        .UART_TX_O  (UART_TX_O)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin : baud_gen
        int cyc;
        cyc = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge Clk);
            cyc = cyc + 1;
            baud_tick = ((cyc % 4) == 0);
        end
    end

    task automatic write_byte(input logic [7:0] b);
        TX_data    = b;
        wr_uart_en = 1'b1;
        @(negedge Clk);
        wr_uart_en = 1'b0;
    endtask

    task automatic wait_fall(input int budget, input bit chk_busy, input string tag);
        int  n;
        bit  gap;
        n   = 0;
        gap = 1'b0;
        while (UART_TX_O !== 1'b0 && n < budget) begin
            @(negedge Clk);
            n++;
            if (chk_busy && Busy !== 1'b1) gap = 1'b1;
        end
        checks++;
        if (UART_TX_O !== 1'b0) begin
            errors++;
            $display("FAIL %s_start: line=%b after %0d cycles, required 0", tag, UART_TX_O, n);
        end
        if (chk_busy) begin
            checks++;
            if (gap) begin
                errors++;
                $display("FAIL %s_no_gap: Busy dropped between frames, required Busy=1", tag);
            end
        end
    endtask

    // Called at the falling edge where the start bit is first seen.
    task automatic capture(input int drop_bit, input string tag, output logic [7:0] d);
        d = 8'h00;
        repeat (32) @(negedge Clk);
        checks++;
        if (UART_TX_O !== 1'b0) begin
            errors++;
            $display("FAIL %s_start_bit: line=%b, required 0", tag, UART_TX_O);
        end
        for (int k = 0; k < 8; k++) begin
            repeat (64) @(negedge Clk);
            d[k] = UART_TX_O;
            if (k == drop_bit) Enable = 1'b0;
        end
        repeat (64) @(negedge Clk);
        checks++;
        if (UART_TX_O !== 1'b1) begin
            errors++;
            $display("FAIL %s_stop_bit: line=%b, required 1", tag, UART_TX_O);
        end
    endtask

    task automatic test_reset();
        Resetn     = 1'b0;
        Enable     = 1'b0;
        TX_data    = 8'h00;
        wr_uart_en = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if ({UART_TX_O, Full, Empty, Busy, Write_drop} !== 5'b10100) begin
            errors++;
            $display("FAIL reset_values: {tx,full,empty,busy,drop}=%b, required 10100",
                     {UART_TX_O, Full, Empty, Busy, Write_drop});
        end
        Resetn = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk);
            if (UART_TX_O !== 1'b1 || Empty !== 1'b1 || Busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_line: %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] v;
        logic       lvl [700];
        logic       bsy [700];
        int         r;
        int         bad;
        logic       exp_l;
        v = 8'hA5;
        Enable = 1'b1;
        write_byte(v);
        checks++;
        if (Empty !== 1'b0 || UART_TX_O !== 1'b1) begin
            errors++;
            $display("FAIL single_after_write: empty=%b tx=%b, required empty=0 tx=1", Empty, UART_TX_O);
        end
        @(negedge Clk);
        checks++;
        if (UART_TX_O !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL single_start_edge: tx=%b busy=%b, required tx=0 busy=1", UART_TX_O, Busy);
        end
        for (int i = 0; i < 700; i++) begin
            lvl[i] = UART_TX_O;
            bsy[i] = Busy;
            @(negedge Clk);
        end
        r = -1;
        for (int i = 1; i < 80; i++) begin
            if (r < 0 && lvl[i] === 1'b1) r = i;
        end
        checks++;
        if (r < 61 || r > 64) begin
            errors++;
            $display("FAIL single_start_len: %0d cycles, required 61..64", r);
            r = 64;
        end
        bad = 0;
        for (int i = r; i < 700; i++) begin
            exp_l = ((i - r) / 64 < 8) ? v[(i - r) / 64] : 1'b1;
            if (lvl[i] !== exp_l) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL single_bits: %0d samples differ from 1,0,1,0,0,1,0,1 then stop, required 0", bad);
        end
        checks++;
        if (bsy[r + 575] !== 1'b1 || bsy[r + 576] !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_end: busy=%b,%b at stop end, required 1,0",
                     bsy[r + 575], bsy[r + 576]);
        end
    endtask

    task automatic test_full_drop();
        logic [7:0] d;
        int         drops;
        Enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            write_byte(8'(i));
            if (i == 14) begin
                checks++;
                if (Full !== 1'b0) begin
                    errors++;
                    $display("FAIL full_at_15: full=%b, required 0", Full);
                end
            end
        end
        checks++;
        if (Full !== 1'b1) begin
            errors++;
            $display("FAIL full_at_16: full=%b, required 1", Full);
        end
        write_byte(8'h10);
        drops = (Write_drop === 1'b1) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (Write_drop === 1'b1) drops++;
        end
        checks++;
        if (drops != 1 || Full !== 1'b1) begin
            errors++;
            $display("FAIL write_drop: %0d pulses full=%b, required 1 pulse full=1", drops, Full);
        end
        Enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_fall((i == 0) ? 100 : 60, i != 0, "drain");
            capture(-1, "drain", d);
            checks++;
            if (d !== 8'(i)) begin
                errors++;
                $display("FAIL drain_byte%0d: got %02h, required %02h", i, d, 8'(i));
            end
        end
        repeat (80) @(negedge Clk);
        checks++;
        if (Empty !== 1'b1 || Busy !== 1'b0 || UART_TX_O !== 1'b1) begin
            errors++;
            $display("FAIL drain_done: empty=%b busy=%b tx=%b, required 1 0 1", Empty, Busy, UART_TX_O);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] d;
        Enable = 1'b0;
        write_byte(8'h11);
        Enable     = 1'b1;
        TX_data    = 8'h22;
        wr_uart_en = 1'b1;
        @(negedge Clk);
        wr_uart_en = 1'b0;
        checks++;
        if (Empty !== 1'b0 || Full !== 1'b0 || Busy !== 1'b1 || UART_TX_O !== 1'b0) begin
            errors++;
            $display("FAIL simul_occupancy: empty=%b full=%b busy=%b tx=%b, required 0 0 1 0",
                     Empty, Full, Busy, UART_TX_O);
        end
        capture(-1, "simul", d);
        checks++;
        if (d !== 8'h11) begin
            errors++;
            $display("FAIL simul_byte0: got %02h, required 11", d);
        end
        wait_fall(60, 1'b1, "simul");
        capture(-1, "simul", d);
        checks++;
        if (d !== 8'h22) begin
            errors++;
            $display("FAIL simul_byte1: got %02h, required 22", d);
        end
        repeat (80) @(negedge Clk);
        checks++;
        if (Empty !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL simul_done: empty=%b busy=%b, required 1 0", Empty, Busy);
        end
    endtask

    task automatic test_enable_drop();
        logic [7:0] d;
        int         bad;
        Enable = 1'b0;
        write_byte(8'h5A);
        write_byte(8'hC3);
        write_byte(8'h0F);
        Enable = 1'b1;
        wait_fall(100, 1'b0, "endrop");
        capture(3, "endrop", d);
        checks++;
        if (d !== 8'h5A) begin
            errors++;
            $display("FAIL endrop_byte0: got %02h, required 5A", d);
        end
        repeat (40) @(negedge Clk);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (UART_TX_O !== 1'b1 || Busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || Empty !== 1'b0) begin
            errors++;
            $display("FAIL endrop_hold: %0d active cycles empty=%b, required 0 and empty=0", bad, Empty);
        end
        Enable = 1'b1;
        wait_fall(20, 1'b0, "endrop");
        capture(-1, "endrop", d);
        checks++;
        if (d !== 8'hC3) begin
            errors++;
            $display("FAIL endrop_byte1: got %02h, required C3", d);
        end
        wait_fall(60, 1'b1, "endrop");
        capture(-1, "endrop", d);
        checks++;
        if (d !== 8'h0F) begin
            errors++;
            $display("FAIL endrop_byte2: got %02h, required 0F", d);
        end
        repeat (80) @(negedge Clk);
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        Enable = 1'b1;
        write_byte(8'h00);
        write_byte(8'h55);
        wait_fall(100, 1'b0, "rstmid");
        repeat (32 + 64 * 6) @(negedge Clk);
        checks++;
        if (UART_TX_O !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_bit5: tx=%b busy=%b, required 0 1", UART_TX_O, Busy);
        end
        Resetn = 1'b0;
        #1;
        checks++;
        if (UART_TX_O !== 1'b1 || Empty !== 1'b1 || Busy !== 1'b0 || Full !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: tx=%b empty=%b busy=%b full=%b, required 1 1 0 0",
                     UART_TX_O, Empty, Busy, Full);
        end
        @(negedge Clk);
        Resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk);
            if (UART_TX_O !== 1'b1 || Empty !== 1'b1 || Busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rstmid_after: %0d active cycles, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_byte();
        test_full_drop();
        test_simultaneous();
        test_enable_drop();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmit path: accepts bytes from the host side through a write-enable/Full handshake, stores them in an internal FIFO, and serializes them 8N1 (LSB first) on the TX pin, paced by the shared baud tick generator. It is the transmit-direction counterpart to the receive controller's Empty/unload interface and replaces the unbuffered transmit controller inside the UART top.

## Interface

Parameters:
- DATA_DEPTH, 16: FIFO depth in bytes; power of two, at least 2.
- C_OVERSAMPLE, 16: baud_tick pulses per UART bit; at least 2.

Ports:
- Clk  input  1  system clock; all logic is on the rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- baud_tick  input  1  one-cycle pulse at C_OVERSAMPLE × baud rate, from the bridge.
- Enable  input  1  permits new frames to start; it never aborts a frame in progress.
- TX_data  input  8  byte to enqueue.
- wr_uart_en  input  1  write strobe; a byte is accepted when wr_uart_en=1 and Full=0.
- Full  output  1  FIFO holds DATA_DEPTH bytes.
- Empty  output  1  FIFO holds 0 bytes.
- Busy  output  1  a frame is being shifted (state ≠ IDLE).
- Write_drop  output  1  one-cycle pulse when a write arrives while Full=1.
- UART_TX_O  output  1  serial line; idles high.

## Operation

- FIFO: circular buffer with read and write pointers that carry one extra wrap bit, so Full and Empty are derived from the pointers with no separate counter.
  - Full = MSBs differ and lower bits equal. Empty = pointers equal.
- Write rules:
  - An accepted write stores TX_data at the write pointer and increments the pointer modulo 2·DATA_DEPTH.
  - A write with Full=1 is discarded. The FIFO does not change, and Write_drop pulses in the next cycle.
  - Full is evaluated before any same-cycle pop, so a write while full is dropped even if a pop happens in that cycle.
  - A write and a pop in the same cycle with 0 < occupancy < DATA_DEPTH are both performed; occupancy is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if Enable=1 and Empty=0, pop the head byte into the shift register, clear the tick and bit counters, and go to START. Otherwise stay in IDLE.
  - START: UART_TX_O=0. After C_OVERSAMPLE ticks, go to DATA.
  - DATA: UART_TX_O = shift_reg[0]. After every C_OVERSAMPLE ticks, shift right and increment the bit counter. After bit 7 completes, go to STOP.
  - STOP: UART_TX_O=1. When the C_OVERSAMPLE-th tick arrives:
    - if Enable=1 and Empty=0, pop the next byte and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- Counters:
  - The tick counter is $clog2(C_OVERSAMPLE) bits and advances only on baud_tick. It wraps from C_OVERSAMPLE-1 to 0, and that wrap ends the bit period.
  - The bit counter is 3 bits.
- Enable deasserted mid-frame: the current frame completes through STOP, then the FSM holds in IDLE. Queued bytes are retained.
- UART_TX_O is registered; it is driven directly from a flop, never from combinational logic.

## Timing

- Reset values: UART_TX_O=1, Full=0, Empty=1, Busy=0, Write_drop=0, both pointers 0, FSM in IDLE.
- Reset asserted mid-frame: the line returns high immediately (asynchronously) and all queued data is lost.
- Write latency: a write accepted at edge N gives Empty=0 after edge N. The FSM, in IDLE with Enable=1, pops at edge N+1, and UART_TX_O falls after edge N+1.
- Full and Empty reflect the pointers after each edge. Write_drop is registered: it is high for the cycle after the dropped write.
- Frame length: exactly 10·C_OVERSAMPLE baud_tick pulses from the start-bit falling edge to the end of the stop bit.
- Bit transitions occur on the clock edge at which the terminal baud_tick is sampled.
- Busy=1 from the pop cycle through the final STOP tick. If a back-to-back frame follows, Busy stays 1.

## Structure

- Shared package uart_pkg:
  - typedef enum uart_tx_state_e {IDLE, START, DATA, STOP};
  - localparams UART_DATA_BITS=8, UART_STOP_BITS=1, UART_IDLE_LEVEL=1'b1.
- Sub-module uart_sync_fifo, parameterized by width and depth: write/read strobes, registered Full and Empty, and a read-data output that shows the head byte combinationally.
- Top level: the FSM, the two counters, the shift register, and the TX flop.

## Test plan

Common setup: C_OVERSAMPLE=16, with baud_tick pulsing every 4th cycle (one bit = 64 cycles, one frame = 640 cycles).

- Idle line after reset: no stimulus -> UART_TX_O=1, Empty=1, Busy=0 for 1000 cycles.
- Single byte: write 0xA5 with Enable=1 -> line shows 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1. Each bit lasts 64 cycles; the start edge comes 1 cycle after Empty deasserts.
- Full and drop: Enable=0, write 17 bytes 0x00..0x10 with DATA_DEPTH=16 -> Full=1 after the 16th write. The 17th write pulses Write_drop once. Then Enable=1 -> exactly 0x00..0x0F appear on the line, with no gaps between frames.
- Simultaneous write and pop: with occupancy 1, a write lands in the same cycle the FSM pops -> occupancy stays 1, and no byte is lost or duplicated.
- Enable dropped mid-frame: deassert Enable during the DATA bit-3 period with 2 bytes queued -> the current frame finishes with its stop bit, the line stays high, and Empty=0. Re-enabling sends the next byte.
- Reset mid-frame: Resetn low during bit 5 -> UART_TX_O=1 within the same cycle, Empty=1, and no further frames after release.
